// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the data-memory path: FSM state encoding, word
// geometry and default sizing. The core's stall logic imports this package
// as well, so both sides agree on latency and depth defaults.
package olivia_mem_pkg;

    localparam int WORD_BYTES      = 8;
    localparam int WORD_SHIFT      = 3;
    localparam int DEFAULT_LATENCY = 2;
    localparam int DEFAULT_DEPTH   = 256;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } mem_state_e;

    // Width of the latency counter: ceil(log2(latency)), never below 1.
    function automatic int cnt_width(input int latency);
        if (latency <= 2) begin
            return 1;
        end else begin
            return $clog2(latency);
        end
    endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Load/store handshake between the core's MEM stage (master) and the
// data-memory responder (slave).
//   mem_read/mem_write : request strobes, held by the core until accepted
//   addr/wr_data       : byte address and store data
//   req_ready          : responder can accept a request this cycle
//   rsp_valid          : one-cycle response pulse
//   rd_data/addr_err   : load data and illegal-access flag for the response
interface data_mem_responder_if;

    logic        mem_read;
    logic        mem_write;
    logic [63:0] addr;
    logic [63:0] wr_data;
    logic        req_ready;
    logic        rsp_valid;
    logic [63:0] rd_data;
    logic        addr_err;

    modport master (
        output mem_read, mem_write, addr, wr_data,
        input  req_ready, rsp_valid, rd_data, addr_err
    );

    modport slave (
        input  mem_read, mem_write, addr, wr_data,
        output req_ready, rsp_valid, rd_data, addr_err
    );

endinterface

// File: rtl/data_mem_responder_array.sv
// Single-port doubleword storage: synchronous write, registered read.
// Contents are deliberately not reset.
//   clk   : clock
//   we    : write index with wdata on the rising edge
//   re    : capture the word at index into rdata on the rising edge
//   index : word index
//   wdata : write data
//   rdata : registered read data, holds until the next read
module data_mem_array
    import olivia_mem_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    localparam int IDX_W  = $clog2(DEPTH),
    localparam int WORD_W = WORD_BYTES * 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [IDX_W-1:0]  index,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem_r [DEPTH];
    logic [WORD_W-1:0] rdata_r;

    // Storage write and registered read port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[index] <= wdata;
        end
        if (re) begin
            rdata_r <= mem_r[index];
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side end of the core's load/store port. Accepts one request at a
// time, answers LATENCY cycles later with a one-cycle rsp_valid pulse, and
// rejects misaligned, out-of-range or double-strobe accesses with addr_err
// instead of touching storage.
//   clk, rst : clock and asynchronous active-high reset
//   bus      : slave side of data_mem_responder_if
module data_mem_responder
    import olivia_mem_pkg::*;
#(
    parameter int DEPTH   = DEFAULT_DEPTH,
    parameter int LATENCY = DEFAULT_LATENCY
) (
    input  logic                  clk,
    input  logic                  rst,
    data_mem_responder_if.slave   bus
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = cnt_width(LATENCY);
    // Acceptance cycle plus the RESP cycle account for two of the LATENCY
    // cycles; the counter covers the rest of the WAIT stretch.
    localparam logic [CNT_W-1:0] CNT_LOAD =
        (LATENCY >= 2) ? CNT_W'(LATENCY - 2) : {CNT_W{1'b0}};

    mem_state_e        state_r, state_s;
    logic [CNT_W-1:0]  cnt_r, cnt_s;
    logic              req_s, accept_s;
    logic              misalign_s, range_s, both_s, illegal_s;
    logic              we_s, re_s;
    logic              pend_err_r, pend_store_r;
    logic              rsp_valid_r, addr_err_r;
    logic [63:0]       hold_r;
    logic [63:0]       rd_data_s;
    logic [63:0]       arr_rdata_s;

    assign req_s      = bus.mem_read | bus.mem_write;
    assign accept_s   = bus.req_ready & req_s & ~rst;
    assign misalign_s = (bus.addr[WORD_SHIFT-1:0] != {WORD_SHIFT{1'b0}});
    assign range_s    = |bus.addr[63:WORD_SHIFT+IDX_W];
    assign both_s     = bus.mem_read & bus.mem_write;
    assign illegal_s  = misalign_s | range_s | both_s;
    assign we_s       = accept_s & ~illegal_s & bus.mem_write;
    assign re_s       = accept_s & ~illegal_s & bus.mem_read;

    data_mem_array #(
        .DEPTH (DEPTH)
    ) u_array (
        .clk   (clk),
        .we    (we_s),
        .re    (re_s),
        .index (bus.addr[WORD_SHIFT +: IDX_W]),
        .wdata (bus.wr_data),
        .rdata (arr_rdata_s)
    );

    // Next-state and counter logic.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        case (state_r)
            ST_IDLE, ST_RESP: begin
                if (accept_s) begin
                    if (LATENCY == 1) begin
                        state_s = ST_RESP;
                    end else begin
                        state_s = ST_WAIT;
                        cnt_s   = CNT_LOAD;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_r == {CNT_W{1'b0}}) begin
                    state_s = ST_RESP;
                end else begin
                    cnt_s = cnt_r - CNT_W'(1'b1);
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    // Response data: loads show the array read register, illegal accesses
    // show zero, stores keep whatever the previous response showed. Outside
    // RESP the last shown value is held.
    always_comb begin
        rd_data_s = hold_r;
        if (state_r == ST_RESP) begin
            if (pend_err_r) begin
                rd_data_s = 64'd0;
            end else if (pend_store_r) begin
                rd_data_s = hold_r;
            end else begin
                rd_data_s = arr_rdata_s;
            end
        end else begin
            rd_data_s = hold_r;
        end
    end

    // State, counter, pending-access flags and registered response outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            cnt_r        <= {CNT_W{1'b0}};
            pend_err_r   <= 1'b0;
            pend_store_r <= 1'b0;
            rsp_valid_r  <= 1'b0;
            addr_err_r   <= 1'b0;
            hold_r       <= 64'd0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            if (accept_s) begin
                pend_err_r   <= illegal_s;
                pend_store_r <= bus.mem_write;
            end
            rsp_valid_r <= (state_s == ST_RESP);
            addr_err_r  <= (state_s == ST_RESP) &&
                           (accept_s ? illegal_s : pend_err_r);
            if (state_r == ST_RESP) begin
                hold_r <= rd_data_s;
            end
        end
    end

    assign bus.req_ready = (state_r != ST_WAIT);
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.addr_err  = addr_err_r;
    assign bus.rd_data   = rd_data_s;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder with LATENCY 2, 1 and 4 instances.
// Expected responses are pushed to per-instance scoreboards at acceptance
// and checked by a negedge monitor in the cycle they are due.
module tb_data_mem_responder;

    localparam int DEPTH = 256;

    typedef struct {
        bit          err;
        bit          store;
        logic [63:0] data;
        int          due;
    } rsp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mr [3];
    logic        mw [3];
    logic [63:0] ad [3];
    logic [63:0] wd [3];
    logic        rr [3];
    logic        rv [3];
    logic        ae [3];
    logic [63:0] rd [3];

    rsp_t        sbq [3][$];
    logic [63:0] mdl [3][DEPTH];
    logic [63:0] last_rd [3];
    int          acc_cyc [3];
    int          cyc = 0;
    int          n_assert = 0;
    int          n_fail = 0;
    bit          mon_en = 1'b0;

    always #5 clk = ~clk;

    data_mem_responder_if b0 ();
    data_mem_responder_if b1 ();
    data_mem_responder_if b2 ();

    assign b0.mem_read = mr[0]; assign b0.mem_write = mw[0];
    assign b0.addr = ad[0];     assign b0.wr_data = wd[0];
    assign rr[0] = b0.req_ready; assign rv[0] = b0.rsp_valid;
    assign ae[0] = b0.addr_err;  assign rd[0] = b0.rd_data;

    assign b1.mem_read = mr[1]; assign b1.mem_write = mw[1];
    assign b1.addr = ad[1];     assign b1.wr_data = wd[1];
    assign rr[1] = b1.req_ready; assign rv[1] = b1.rsp_valid;
    assign ae[1] = b1.addr_err;  assign rd[1] = b1.rd_data;

    assign b2.mem_read = mr[2]; assign b2.mem_write = mw[2];
    assign b2.addr = ad[2];     assign b2.wr_data = wd[2];
    assign rr[2] = b2.req_ready; assign rv[2] = b2.rsp_valid;
    assign ae[2] = b2.addr_err;  assign rd[2] = b2.rd_data;

    data_mem_responder #(.DEPTH(DEPTH), .LATENCY(2)) u_l2 (.clk(clk), .rst(rst), .bus(b0));
    data_mem_responder #(.DEPTH(DEPTH), .LATENCY(1)) u_l1 (.clk(clk), .rst(rst), .bus(b1));
    data_mem_responder #(.DEPTH(DEPTH), .LATENCY(4)) u_l4 (.clk(clk), .rst(rst), .bus(b2));

    function automatic int lat(input int k);
        case (k)
            0:       return 2;
            1:       return 1;
            default: return 4;
        endcase
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Response monitor: ready, valid, error flag and data against the scoreboard.
    always @(negedge clk) begin : mon
        rsp_t        it;
        logic        ev;
        logic        er;
        logic [63:0] ed;
        if (mon_en) begin
            for (int k = 0; k < 3; k++) begin
                ev = (sbq[k].size() > 0) && (sbq[k][0].due == cyc);
                er = (sbq[k].size() == 0) || (sbq[k][0].due <= cyc);
                check($sformatf("req_ready[%0d]@%0d", k, cyc), 64'(rr[k]), 64'(er));
                check($sformatf("rsp_valid[%0d]@%0d", k, cyc), 64'(rv[k]), 64'(ev));
                if (ev) begin
                    it = sbq[k].pop_front();
                    ed = it.err ? 64'd0 : (it.store ? last_rd[k] : it.data);
                    check($sformatf("addr_err[%0d]@%0d", k, cyc), 64'(ae[k]), 64'(it.err));
                    check($sformatf("rd_data[%0d]@%0d", k, cyc), rd[k], ed);
                    last_rd[k] = ed;
                end else begin
                    check($sformatf("rd_hold[%0d]@%0d", k, cyc), rd[k], last_rd[k]);
                end
            end
        end
    end

    // Present a request and hold it until accepted; on acceptance push the expectation.
    task automatic do_req(input int k, input logic r, input logic w,
                          input logic [63:0] a, input logic [63:0] d);
        rsp_t it;
        bit   done;
        done  = 1'b0;
        mr[k] = r; mw[k] = w; ad[k] = a; wd[k] = d;
        for (int g = 0; g < 16 && !done; g++) begin
            @(negedge clk);
            if (rr[k] === 1'b1) begin
                @(posedge clk);
                #1;
                it.err   = (a[2:0] != 3'd0) || (a[63:3] >= 61'(DEPTH)) || (r && w);
                it.store = w;
                it.due   = cyc + lat(k) - 1;
                it.data  = (!it.err && r) ? mdl[k][a[10:3]] : 64'd0;
                if (!it.err && w) mdl[k][a[10:3]] = d;
                sbq[k].push_back(it);
                acc_cyc[k] = cyc;
                done = 1'b1;
            end
        end
        check($sformatf("accept[%0d] addr=%h", k, a), 64'(done), 64'd1);
    endtask

    // Drop the strobes and wait (bounded) for the outstanding response.
    task automatic idle(input int k);
        mr[k] = 1'b0; mw[k] = 1'b0;
        for (int g = 0; g < 20; g++) begin
            if (sbq[k].size() == 0) break;
            @(posedge clk);
            #1;
        end
        check($sformatf("drain[%0d]", k), 64'(sbq[k].size()), 64'd0);
    endtask

    // Continuous requests: four stores then four loads, checking acceptance spacing.
    task automatic stream(input int k);
        int p;
        p = 0;
        for (int i = 0; i < 8; i++) begin
            if (i < 4) do_req(k, 1'b0, 1'b1, 64'(i * 8), 64'hA5A5_0000_0000_0000 | 64'(i * 17 + k));
            else       do_req(k, 1'b1, 1'b0, 64'((i - 4) * 8), 64'd0);
            if (i > 0) check($sformatf("spacing[%0d] #%0d", k, i), 64'(acc_cyc[k] - p), 64'(lat(k)));
            p = acc_cyc[k];
        end
        idle(k);
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            mr[k] = 1'b0; mw[k] = 1'b0; ad[k] = 64'd0; wd[k] = 64'd0;
            last_rd[k] = 64'd0; acc_cyc[k] = 0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("rst_ready[%0d]", k), 64'(rr[k]), 64'd1);
            check($sformatf("rst_valid[%0d]", k), 64'(rv[k]), 64'd0);
            check($sformatf("rst_err[%0d]", k), 64'(ae[k]), 64'd0);
            check($sformatf("rst_rd[%0d]", k), rd[k], 64'd0);
        end
        rst = 1'b0;
        mon_en = 1'b1;

        // Known contents for words 1 and 3.
        do_req(0, 1'b0, 1'b1, 64'h08, 64'h1111_2222_3333_4444); idle(0);
        do_req(0, 1'b0, 1'b1, 64'h18, 64'h5555_6666_7777_8888); idle(0);
        // Store then load the same word.
        do_req(0, 1'b0, 1'b1, 64'h10, 64'hDEAD_BEEF_CAFE_F00D); idle(0);
        do_req(0, 1'b1, 1'b0, 64'h10, 64'd0);                   idle(0);
        // Misaligned load and store; word 1 untouched.
        do_req(0, 1'b1, 1'b0, 64'h0C, 64'd0);                   idle(0);
        do_req(0, 1'b0, 1'b1, 64'h0C, 64'hFFFF_0000_FFFF_0000); idle(0);
        do_req(0, 1'b1, 1'b0, 64'h08, 64'd0);                   idle(0);
        // Out of range load, double strobe, word 3 untouched.
        do_req(0, 1'b1, 1'b0, 64'(DEPTH * 8), 64'd0);           idle(0);
        do_req(0, 1'b1, 1'b1, 64'h18, 64'h0BAD_0BAD_0BAD_0BAD); idle(0);
        do_req(0, 1'b1, 1'b0, 64'h18, 64'd0);                   idle(0);

        // Reset during WAIT after a store: response dropped, store kept.
        do_req(0, 1'b0, 1'b1, 64'h20, 64'h0123_4567_89AB_CDEF);
        mr[0] = 1'b0; mw[0] = 1'b0;
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            sbq[k].delete();
            last_rd[k] = 64'd0;
        end
        #1;
        check("midwait_rst_valid", 64'(rv[0]), 64'd0);
        check("midwait_rst_err", 64'(ae[0]), 64'd0);
        check("midwait_rst_rd", rd[0], 64'd0);
        check("midwait_rst_ready", 64'(rr[0]), 64'd1);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        do_req(0, 1'b1, 1'b0, 64'h20, 64'd0); idle(0);

        // Back-to-back throughput for every latency.
        for (int k = 0; k < 3; k++) stream(k);

        repeat (6) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) check($sformatf("final_empty[%0d]", k), 64'(sbq[k].size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
